fringe_sequencer: RTL and testbench
===================================

// Module: fringe_sequencer
// PURPOSE
// - Clocked, synchronous frame sequencer that sits directly upstream of the row-rate cosine DDS.
// - Per displayed frame it produces the DDS phase increment (fringe period) and phase offset (8-step shift).
// - Arms the camera trigger after a 2-frame settling delay.
// - Inputs: vertical sync plus the camera trigger-enable and frame-ready handshakes.
// PARAMETERS
// - FRAME_MAX  480  frames per sequence; frame_idx wraps FRAME_MAX-1 -> 0
// - N_STEPS    8    phase steps per period; must be a power of 2; co_n = frame_idx % N_STEPS
// - ARM_FRAMES 2    VS falling edges spent in ARM1/ARM2 before LIVE
// PORTS
// - clk_25        in   1   25 MHz pixel clock
// - reset_n       in   1   asynchronous, active-low reset
// - vga_vs        in   1   vertical sync from the VSYNC rsff, same clock domain
// - sync_in_1     in   1   camera trigger-enable (asynchronous, isolated input)
// - sync_in_2     in   1   camera frame-ready (asynchronous)
// - phase_inc     out  32  DDS pinc_in = round(2^32/(N_STEPS*co_k))
// - poff          out  32  DDS poff_in = co_n * 2^32/N_STEPS
// - frame_idx     out  16  current frame number
// - co_n          out  3   phase-step index
// - co_k          out  7   period index = frame_idx/N_STEPS + 1
// - params_vld    out  1   one-cycle pulse when new phase_inc/poff are stable
// - cam_trig      out  1   sync_out_1: equals vga_vs in LIVE, else 0
// - seq_active    out  1   high whenever state != IDLE
// BEHAVIOUR
// - Reset values:
//   - phase_inc = 32'd536870912; poff = 0; frame_idx = 0; co_n = 0; co_k = 1.
//   - params_vld = 0; cam_trig = 0; seq_active = 0; state = IDLE.
// - Input synchronisers: sync_in_1 and sync_in_2 each pass through a 2-FF synchroniser.
//   - Their outputs (s1, s2) are the only versions used internally.
// - vs_fall: one-cycle strobe, vga_vs registered 1 -> 0.
// - Arm FSM: IDLE -> ARM1 -> ARM2 -> LIVE.
//   - s1 = 0 in any state -> IDLE next cycle, with frame_idx <= 0.
//   - IDLE with s1 = 1: on vs_fall -> ARM1.
//   - ARM1 / ARM2: on vs_fall with s2 = 1, advance one state; with s2 = 0, hold.
//   - LIVE: holds while s1 = 1.
// - Frame counter:
//   - Updates only on vs_fall with s1 = 1 and s2 = 1.
//   - Update rule: frame_idx <= (frame_idx == FRAME_MAX-1) ? 0 : frame_idx + 1.
//   - s2 = 0 at vs_fall: hold.
//   - It counts in ARM1/ARM2/LIVE; it does not count in IDLE.
// - Parameter update, one cycle after a frame_idx change:
//   - co_n = frame_idx[2:0]; co_k = frame_idx>>3 + 1 (shift is log2(N_STEPS)).
//   - poff = co_n << 29 (for N_STEPS = 8), committed together with phase_inc.
// - Divider (sub-module): computes q = floor((2^30/co_k + 1)/2), i.e. round(2^29/co_k).
//   - Unsigned restoring division: 31-bit dividend, 7-bit divisor, 1 quotient bit per cycle.
//   - Result is ready in 32 cycles from start.
//   - Check values: co_k = 3 -> 178956971; co_k = 60 -> 8947849.
// - Commit timing: phase_inc and poff update together in the same cycle.
//   - That cycle is 34 clk_25 after vs_fall; params_vld pulses in the same cycle.
//   - This lands well inside VS low (>= 1600 clk), so the DDS never sees a split update.
// - A new vs_fall arriving while the divider is busy is impossible at legal VGA timing.
//   - If it does occur: the divider restarts with the newest co_k and the pending commit is dropped.
// - reset_n asserted mid-division: divider aborts; all outputs return to reset values asynchronously.
// - cam_trig: combinational AND of (state == LIVE) and registered vga_vs.
//   - It is glitch-free because both terms are registered.
// STRUCTURE
// - Shared package fringe_pkg:
//   - FRAME_MAX, N_STEPS, PINC_BASE = 32'd536870912.
//   - Arm-state encoding: IDLE = 2'b11, ARM1 = 2'b10, ARM2 = 2'b01, LIVE = 2'b00.
// - One sub-module: seq_divider.
//   - Ports: clk_25, reset_n, start, divisor[6:0], busy, done, quotient[31:0].
// - Top level holds the synchronisers, the arm FSM, the frame counter and the commit registers.
// TESTING
// - Reset, then s1 = s2 = 1 with 4 VS frames:
//   - States IDLE -> ARM1 -> ARM2 -> LIVE.
//   - cam_trig first follows vga_vs on the 4th frame.
// - Frames 0..9:
//   - poff steps 0, 536870912, ... 3758096384, then back to 0 at frame 8.
//   - phase_inc = 268435456 from frame 8; params_vld pulses once per frame.
// - Force frame_idx to 479, then one vs_fall:
//   - frame_idx -> 0, co_k -> 1, phase_inc -> 536870912.
// - Hold s2 = 0 across 3 vs_fall in LIVE: frame_idx and params unchanged, no params_vld.
// - Drop s1 in LIVE mid-frame: within 3 clk, state = IDLE, frame_idx = 0, cam_trig = 0.
// - Assert reset_n mid-division (co_k = 37):
//   - Immediate reset values; after release, the next commit gives phase_inc = 14510025 at co_k = 37.

Source files
------------

// File: rtl/fringe_pkg.sv
// Shared constants, arm-state encoding and small helpers for the fringe
// projection frame sequencer and its divider.
package fringe_pkg;

   localparam int          FRAME_MAX  = 480;
   localparam int          N_STEPS    = 8;
   localparam int          STEP_BITS  = $clog2(N_STEPS);
   localparam logic [15:0] FRAME_LAST = 16'(FRAME_MAX - 1);
   localparam logic [31:0] PINC_BASE  = 32'd536870912;

   // 2^30: twice the 2^29 numerator, so the extra quotient bit gives rounding
   localparam logic [30:0] DIV_DIVIDEND = 31'h4000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'b11,
      ARM1 = 2'b10,
      ARM2 = 2'b01,
      LIVE = 2'b00
   } arm_state_t;

   // Period index for a frame number: one period lasts N_STEPS frames
   function automatic logic [6:0] period_index(input logic [15:0] idx);
      return 7'(idx >> STEP_BITS) + 7'd1;
   endfunction

   // Phase offset of step co: co * 2^32 / N_STEPS
   function automatic logic [31:0] step_offset(input logic [2:0] co);
      return 32'(co) << (32 - STEP_BITS);
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing round(2^29 / divisor) as floor((2^30/d + 1)/2).
// One quotient bit per clock; a start while busy restarts with the new divisor.
module seq_divider
   import fringe_pkg::*;
(
   input  logic        clk_25,
   input  logic        reset_n,
   input  logic        start,
   input  logic [6:0]  divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient
);

   logic [30:0] dvd_reg;
   logic [30:0] q_reg;
   logic [6:0]  rem_reg;
   logic [6:0]  dsr_reg;
   logic [4:0]  cnt_reg;
   logic        busy_reg;
   logic        done_reg;
   logic [31:0] quot_reg;

   logic [7:0]  trial;
   logic        fits;
   logic [6:0]  rem_next;
   logic [30:0] q_next;

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      trial    = {rem_reg, dvd_reg[30]};
      fits     = (trial >= {1'b0, dsr_reg});
      rem_next = fits ? 7'(trial - {1'b0, dsr_reg}) : trial[6:0];
      q_next   = {q_reg[29:0], fits};
   end

   // Iteration state; the rounded result and a one-cycle done land after the 31st step
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         dvd_reg  <= '0;
         q_reg    <= '0;
         rem_reg  <= '0;
         dsr_reg  <= 7'd1;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
         quot_reg <= PINC_BASE;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            dvd_reg  <= DIV_DIVIDEND;
            q_reg    <= '0;
            rem_reg  <= '0;
            dsr_reg  <= divisor;
            cnt_reg  <= 5'd31;
            busy_reg <= 1'b1;
         end else if (busy_reg) begin
            dvd_reg <= {dvd_reg[29:0], 1'b0};
            q_reg   <= q_next;
            rem_reg <= rem_next;
            cnt_reg <= cnt_reg - 5'd1;
            if (cnt_reg == 5'd1) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
               quot_reg <= ({1'b0, q_next} + 32'd1) >> 1;
            end
         end
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign quotient = quot_reg;

endmodule

// File: rtl/fringe_sequencer.sv
// Frame sequencer feeding the row-rate cosine DDS: per frame it derives the
// phase step and period, divides out the phase increment, commits increment
// and offset together, and gates the camera trigger once armed.
module fringe_sequencer
   import fringe_pkg::*;
(
   input  logic        clk_25,
   input  logic        reset_n,
   input  logic        vga_vs,
   input  logic        sync_in_1,
   input  logic        sync_in_2,
   output logic [31:0] phase_inc,
   output logic [31:0] poff,
   output logic [15:0] frame_idx,
   output logic [2:0]  co_n,
   output logic [6:0]  co_k,
   output logic        params_vld,
   output logic        cam_trig,
   output logic        seq_active
);

   logic [1:0]  async_in;
   logic [1:0]  sync_vec;
   logic        s1;
   logic        s2;
   logic        vs_reg;
   logic        vs_fall;
   logic        count_en;
   arm_state_t  state_reg;
   arm_state_t  state_next;
   logic [15:0] frame_idx_reg;
   logic [15:0] frame_idx_next;
   logic        frame_upd_reg;
   logic        div_start_reg;
   logic [2:0]  co_n_reg;
   logic [6:0]  co_k_reg;
   logic [31:0] phase_inc_reg;
   logic [31:0] poff_reg;
   logic        params_vld_reg;
   logic        div_busy;
   logic        div_done;
   logic [31:0] div_quotient;
   logic        commit_en;

   assign async_in = {sync_in_2, sync_in_1};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         // Two-flop synchroniser for one asynchronous camera handshake
         always_ff @(posedge clk_25 or negedge reset_n) begin
            if (!reset_n) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= async_in[gi];
               sync_reg <= meta_reg;
            end
         end
         assign sync_vec[gi] = sync_reg;
      end
   endgenerate

   assign s1 = sync_vec[0];
   assign s2 = sync_vec[1];

   // Delayed copy of vertical sync for edge detection and the trigger gate
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) vs_reg <= 1'b0;
      else          vs_reg <= vga_vs;
   end

   assign vs_fall  = vs_reg & ~vga_vs;
   assign count_en = vs_fall & s1 & s2 & (state_reg != IDLE);

   // Arm state register
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Arm sequencing: losing trigger-enable always drops back to IDLE
   always_comb begin
      state_next = state_reg;
      if (!s1) begin
         state_next = IDLE;
      end else if (vs_fall) begin
         unique case (state_reg)
            IDLE:    state_next = ARM1;
            ARM1:    state_next = s2 ? ARM2 : ARM1;
            ARM2:    state_next = s2 ? LIVE : ARM2;
            default: state_next = LIVE;
         endcase
      end
   end

   // Next frame number: cleared while disabled, wraps at the sequence length
   always_comb begin
      frame_idx_next = frame_idx_reg;
      if (!s1) begin
         frame_idx_next = '0;
      end else if (count_en) begin
         frame_idx_next = (frame_idx_reg == FRAME_LAST) ? 16'd0 : frame_idx_reg + 16'd1;
      end
   end

   // Frame counter
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) frame_idx_reg <= '0;
      else          frame_idx_reg <= frame_idx_next;
   end

   // Step/period derivation one cycle after a count, then kick the divider
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         frame_upd_reg <= 1'b0;
         div_start_reg <= 1'b0;
         co_n_reg      <= '0;
         co_k_reg      <= 7'd1;
      end else begin
         frame_upd_reg <= count_en;
         div_start_reg <= frame_upd_reg;
         if (frame_upd_reg) begin
            co_n_reg <= frame_idx_reg[STEP_BITS-1:0];
            co_k_reg <= period_index(frame_idx_reg);
         end
      end
   end

   seq_divider u_div (
      .clk_25   (clk_25),
      .reset_n  (reset_n),
      .start    (div_start_reg),
      .divisor  (co_k_reg),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quotient)
   );

   // A result superseded by a fresh start is never committed
   assign commit_en = div_done & ~div_busy & ~div_start_reg;

   // Increment and offset change in the same cycle so the DDS never sees a split pair
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         phase_inc_reg  <= PINC_BASE;
         poff_reg       <= '0;
         params_vld_reg <= 1'b0;
      end else begin
         params_vld_reg <= commit_en;
         if (commit_en) begin
            phase_inc_reg <= div_quotient;
            poff_reg      <= step_offset(co_n_reg);
         end
      end
   end

   assign phase_inc  = phase_inc_reg;
   assign poff       = poff_reg;
   assign frame_idx  = frame_idx_reg;
   assign co_n       = co_n_reg;
   assign co_k       = co_k_reg;
   assign params_vld = params_vld_reg;
   assign cam_trig   = (state_reg == LIVE) & vs_reg;
   assign seq_active = (state_reg != IDLE);

endmodule

// File: tb/tb_fringe_sequencer.sv
// Directed bench for fringe_sequencer: arming, per-frame parameter commits,
// sequence wrap, handshake holds, trigger-enable drop and reset mid-division.
`timescale 1ns/1ps
module tb_fringe_sequencer;
   import fringe_pkg::*;

   logic        clk_25 = 1'b0;
   logic        reset_n = 1'b0;
   logic        vga_vs = 1'b1;
   logic        sync_in_1 = 1'b0;
   logic        sync_in_2 = 1'b0;
   logic [31:0] phase_inc;
   logic [31:0] poff;
   logic [15:0] frame_idx;
   logic [2:0]  co_n;
   logic [6:0]  co_k;
   logic        params_vld;
   logic        cam_trig;
   logic        seq_active;

   int checks = 0;
   int errors = 0;

   arm_state_t  m_state;
   int          m_frame;
   int          m_con;
   int          m_cok;
   logic [31:0] m_pinc;
   logic [31:0] m_poff;
   int          vld_cnt;
   int          vld_at;
   int          cam_cnt;

   logic [31:0] poff_tab [0:7];
   arm_state_t  arm_tab  [0:3];

   always #20 clk_25 = ~clk_25;

   fringe_sequencer dut (
      .clk_25     (clk_25),
      .reset_n    (reset_n),
      .vga_vs     (vga_vs),
      .sync_in_1  (sync_in_1),
      .sync_in_2  (sync_in_2),
      .phase_inc  (phase_inc),
      .poff       (poff),
      .frame_idx  (frame_idx),
      .co_n       (co_n),
      .co_k       (co_k),
      .params_vld (params_vld),
      .cam_trig   (cam_trig),
      .seq_active (seq_active)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // round(2^29 / k), half rounding up
   function automatic logic [31:0] pinc_of(input int k);
      longint unsigned num;
      num = (64'd1 << 30) + 64'(k);
      return 32'(num / (64'd2 * 64'(k)));
   endfunction

   task automatic model_reset();
      m_state = IDLE;
      m_frame = 0;
      m_con   = 0;
      m_cok   = 1;
      m_pinc  = 32'd536870912;
      m_poff  = 32'd0;
   endtask

   // One 38-cycle frame: 2 cycles VS high, then VS low for 36 cycles
   task automatic run_frame(input bit verbose);
      logic       s1v;
      logic       s2v;
      arm_state_t prev;
      bit         counted;
      s1v = sync_in_1;
      s2v = sync_in_2;
      vld_cnt = 0;
      vld_at  = -1;
      cam_cnt = 0;
      vga_vs = 1'b1;
      repeat (2) begin
         @(negedge clk_25);
         if (params_vld) vld_cnt++;
         if (cam_trig) cam_cnt++;
      end
      vga_vs = 1'b0;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk_25);
         if (params_vld) begin
            vld_cnt++;
            vld_at = c;
         end
         if (cam_trig) cam_cnt++;
      end
      prev = m_state;
      counted = 1'b0;
      if (s1v) begin
         case (m_state)
            IDLE:    m_state = ARM1;
            ARM1:    if (s2v) m_state = ARM2;
            ARM2:    if (s2v) m_state = LIVE;
            default: m_state = LIVE;
         endcase
         if (prev != IDLE && s2v) begin
            counted = 1'b1;
            m_frame = (m_frame == FRAME_MAX - 1) ? 0 : m_frame + 1;
            m_con   = m_frame % 8;
            m_cok   = m_frame / 8 + 1;
            m_poff  = 32'(m_con) * 32'd536870912;
            m_pinc  = pinc_of(m_cok);
         end
      end else begin
         m_state = IDLE;
         m_frame = 0;
      end
      check_val("state", 32'(dut.state_reg), 32'(m_state));
      check_val("frame_idx", 32'(frame_idx), 32'(m_frame));
      check_val("vld_count", vld_cnt, counted ? 1 : 0);
      check_val("cam_cycles", cam_cnt, (prev == LIVE) ? 2 : 0);
      if (counted) check_val("vld_latency", vld_at, 34);
      check_val("poff", poff, m_poff);
      check_val("phase_inc", phase_inc, m_pinc);
      check_val("co_n", 32'(co_n), 32'(m_con));
      check_val("co_k", 32'(co_k), 32'(m_cok));
      if (counted && m_frame == 16) check_val("pinc_k3", phase_inc, 32'd178956971);
      if (counted && m_frame == 472) check_val("pinc_k60", phase_inc, 32'd8947849);
      if (verbose)
         $display("frame %0d state %s poff %0d phase_inc %0d co_n %0d co_k %0d vld %0d cam %0d",
                  frame_idx, m_state.name(), poff, phase_inc, co_n, co_k, vld_cnt, cam_cnt);
   endtask

   task automatic run_until(input int target);
      int guard;
      guard = 0;
      while (m_frame != target && guard < 600) begin
         run_frame(1'b0);
         guard++;
      end
      check_val("reach_frame", 32'(frame_idx), 32'(target));
   endtask

   // Hand-computed offsets/increments for the first period and a half
   task automatic hand_check();
      if (m_frame >= 1 && m_frame <= 9) begin
         check_val("poff_tab", poff, poff_tab[m_frame % 8]);
         check_val("pinc_tab", phase_inc, (m_frame >= 8) ? 32'd268435456 : 32'd536870912);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_phase_inc"}, phase_inc, 32'd536870912);
      check_val({tag, "_poff"}, poff, 32'd0);
      check_val({tag, "_frame_idx"}, 32'(frame_idx), 32'd0);
      check_val({tag, "_co_n"}, 32'(co_n), 32'd0);
      check_val({tag, "_co_k"}, 32'(co_k), 32'd1);
      check_val({tag, "_params_vld"}, 32'(params_vld), 32'd0);
      check_val({tag, "_cam_trig"}, 32'(cam_trig), 32'd0);
      check_val({tag, "_seq_active"}, 32'(seq_active), 32'd0);
      check_val({tag, "_state"}, 32'(dut.state_reg), 32'(IDLE));
   endtask

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      poff_tab = '{32'd0, 32'd536870912, 32'd1073741824, 32'd1610612736,
                   32'd2147483648, 32'd2684354560, 32'd3221225472, 32'd3758096384};
      arm_tab  = '{ARM1, ARM2, LIVE, LIVE};
      model_reset();

      repeat (3) @(negedge clk_25);
      check_reset_values("rst");
      reset_n = 1'b1;
      sync_in_1 = 1'b1;
      sync_in_2 = 1'b1;
      repeat (4) @(negedge clk_25);
      check_val("idle_no_fall", 32'(seq_active), 32'd0);

      // Arm sequence: trigger follows VS only in the 4th frame
      for (int f = 0; f < 4; f++) begin
         run_frame(1'b1);
         check_val("arm_state", 32'(dut.state_reg), 32'(arm_tab[f]));
         check_val("arm_cam", cam_cnt, (f == 3) ? 2 : 0);
         hand_check();
      end
      check_val("seq_active_live", 32'(seq_active), 32'd1);

      for (int g = 0; g < 20 && m_frame < 9; g++) begin
         run_frame(1'b1);
         hand_check();
      end

      // Sequence wrap
      run_until(479);
      run_frame(1'b1);
      check_val("wrap_frame", 32'(frame_idx), 32'd0);
      check_val("wrap_co_k", 32'(co_k), 32'd1);
      check_val("wrap_pinc", phase_inc, 32'd536870912);
      check_val("wrap_poff", poff, 32'd0);

      // Frame-ready held low: nothing moves
      sync_in_2 = 1'b0;
      repeat (3) @(negedge clk_25);
      for (int f = 0; f < 3; f++) begin
         run_frame(1'b1);
         check_val("s2_hold_frame", 32'(frame_idx), 32'd0);
         check_val("s2_hold_vld", vld_cnt, 0);
      end
      sync_in_2 = 1'b1;
      repeat (3) @(negedge clk_25);

      run_until(288);
      check_val("k37_pinc", phase_inc, 32'd14510025);
      check_val("k37_co_k", 32'(co_k), 32'd37);

      // Reset asserted while the divider works on frame 289
      vga_vs = 1'b1;
      repeat (2) @(negedge clk_25);
      vga_vs = 1'b0;
      repeat (12) @(negedge clk_25);
      check_val("mid_div_frame", 32'(frame_idx), 32'd289);
      check_val("mid_div_co_k", 32'(co_k), 32'd37);
      check_val("mid_div_vld", 32'(params_vld), 32'd0);
      reset_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset();
      repeat (3) @(negedge clk_25);
      check_val("rst_hold_vld", 32'(params_vld), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk_25);
      check_reset_values("post_rst");

      run_until(288);
      check_val("rearm_k37_pinc", phase_inc, 32'd14510025);
      check_val("rearm_k37_co_k", 32'(co_k), 32'd37);
      check_val("rearm_k37_poff", poff, 32'd0);

      // Trigger-enable dropped during the VS pulse in LIVE
      vga_vs = 1'b1;
      repeat (2) @(negedge clk_25);
      check_val("pre_drop_cam", 32'(cam_trig), 32'd1);
      sync_in_1 = 1'b0;
      repeat (3) @(negedge clk_25);
      check_val("drop_state", 32'(dut.state_reg), 32'(IDLE));
      check_val("drop_frame", 32'(frame_idx), 32'd0);
      check_val("drop_cam", 32'(cam_trig), 32'd0);
      check_val("drop_active", 32'(seq_active), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
